// File: rtl/vga_frame_reader.sv
// Raster-order frame reader: walks video memory, absorbs the 1-cycle RAM latency and streams pixels with (x, y).
// Optional `VGA_FRAME_READER_MARKERS_EN adds out_eol/out_eof markers carried through the output FIFO.
module vga_frame_reader #(
   parameter RESOLUTION = "320x240",
   parameter int COLOUR_CHANNEL_DEPTH = 1,
   localparam bit LOW_RES = (RESOLUTION == "160x120"),
   localparam int W  = LOW_RES ? 160 : 320,
   localparam int H  = LOW_RES ? 120 : 240,
   localparam int AW = LOW_RES ? 15 : 17,
   localparam int XW = LOW_RES ? 8 : 9,
   localparam int YW = LOW_RES ? 7 : 8,
   localparam int CW = 3 * COLOUR_CHANNEL_DEPTH
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_address,
   output logic          mem_rden,
   input  logic [CW-1:0] mem_q,
   output logic          out_valid,
   input  logic          out_ready,
`ifdef VGA_FRAME_READER_MARKERS_EN
   output logic          out_eol,
   output logic          out_eof,
`endif
   output logic [CW-1:0] out_colour,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y
);

   localparam logic [XW-1:0] X_LAST = XW'(W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t          state;
   logic [XW-1:0]   x_issue;
   logic [YW-1:0]   y_issue;
   logic            vld_p0;
   logic [XW-1:0]   x_p0;
   logic [YW-1:0]   y_p0;
   logic [CW-1:0]   fifo_colour [2];
   logic [XW-1:0]   fifo_x [2];
   logic [YW-1:0]   fifo_y [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;
   logic            pop;
   logic [2:0]      pending;
   logic            last_issue;
   logic            last_pop;

   // Credit counts the slot freed by a same-cycle pop so a full-rate stream never stalls.
   assign pop        = out_valid & out_ready;
   assign pending    = {1'b0, count} + {2'b00, vld_p0};
   assign mem_rden   = (state == S_SCAN) && (pending < (3'd2 + {2'b00, pop}));
   assign last_issue = (x_issue == X_LAST) && (y_issue == Y_LAST);
   assign last_pop   = pop && (out_x == X_LAST) && (out_y == Y_LAST);

   assign out_valid  = (count != 2'd0);
   assign out_colour = fifo_colour[rd_ptr];
   assign out_x      = fifo_x[rd_ptr];
   assign out_y      = fifo_y[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_address <= '0;
         x_issue     <= '0;
         y_issue     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mem_address <= '0;
                  x_issue     <= '0;
                  y_issue     <= '0;
                  busy        <= 1'b1;
                  state       <= S_SCAN;
               end
            end
            S_SCAN: begin
               // Counters hold on the final read so no address past the frame is ever presented.
               if (mem_rden) begin
                  if (last_issue) begin
                     state <= S_DRAIN;
                  end else begin
                     mem_address <= mem_address + AW'(1);
                     if (x_issue == X_LAST) begin
                        x_issue <= '0;
                        y_issue <= y_issue + YW'(1);
                     end else begin
                        x_issue <= x_issue + XW'(1);
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (last_pop) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Stage p0: coordinates of the read whose data appears on mem_q this cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         x_p0   <= '0;
         y_p0   <= '0;
      end else begin
         vld_p0 <= mem_rden;
         x_p0   <= x_issue;
         y_p0   <= y_issue;
      end
   end

`ifdef VGA_FRAME_READER_MARKERS_EN
   logic fifo_eol [2];
   logic fifo_eof [2];

   assign out_eol = fifo_eol[rd_ptr];
   assign out_eof = fifo_eof[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            fifo_eol[i] <= 1'b0;
            fifo_eof[i] <= 1'b0;
         end
      end else if (vld_p0) begin
         fifo_eol[wr_ptr] <= (x_p0 == X_LAST);
         fifo_eof[wr_ptr] <= (x_p0 == X_LAST) && (y_p0 == Y_LAST);
      end
   end
`endif

   // Output FIFO: two entries, push and pop may coincide when full.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_colour[i] <= '0;
            fifo_x[i]      <= '0;
            fifo_y[i]      <= '0;
         end
      end else begin
         if (vld_p0) begin
            fifo_colour[wr_ptr] <= mem_q;
            fifo_x[wr_ptr]      <= x_p0;
            fifo_y[wr_ptr]      <= y_p0;
            wr_ptr              <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({vld_p0, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
